// File: rtl/walsh_seq_ctrl.sv
// Round-robin scheduler sharing one 8-point Walsh-Hadamard datapath between two requesters.
// Optional build macro WALSH_SEQ_AUTOCHG_EN makes requester 0 change-driven instead of iREQ0-driven.
module walsh_seq_ctrl #(
    parameter int LAT = 2,
    parameter int CW  = 5
) (
    input  logic            iCLK_50,
    input  logic            iRST_N,
    input  logic            iREQ0,
    input  logic [7:0]      iVEC0,
    input  logic            iREQ1,
    input  logic [7:0]      iVEC1,
    output logic            oACK0,
    output logic            oACK1,
    output logic [7:0]      oWH_IN,
    input  logic [8*CW-1:0] iWH_S,
    output logic [8*CW-1:0] oRES,
    output logic            oRES_VALID,
    output logic            oRES_SRC,
    output logic            oBUSY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } stateT;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    stateT      state;
    stateT      stateNext;
    logic       ptr;
    logic       src;
    logic [3:0] cnt;
    logic       req0;
    logic [7:0] vec0;
    logic       anyReq;
    logic       winner;
    logic       grant;

`ifdef WALSH_SEQ_AUTOCHG_EN
    logic [7:0] vec0Meta;
    logic [7:0] vec0Sync;
    logic [7:0] lastVec0;
    logic       firstPend;

    // The switch bank is asynchronous to the clock; requests come from a change in the synchronised value.
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            vec0Meta  <= '0;
            vec0Sync  <= '0;
            lastVec0  <= '0;
            firstPend <= 1'b1;
        end else begin
            vec0Meta <= iVEC0;
            vec0Sync <= vec0Meta;
            if (grant && !winner) begin
                lastVec0  <= vec0Sync;
                firstPend <= 1'b0;
            end
        end
    end

    assign req0 = firstPend || (vec0Sync != lastVec0);
    assign vec0 = vec0Sync;
`else
    assign req0 = iREQ0;
    assign vec0 = iVEC0;
`endif

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        anyReq = req0 || iREQ1;
        winner = (req0 && iREQ1) ? ptr : iREQ1;
        grant  = (state == IDLE) && anyReq;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = WAIT;
            WAIT:    if (cnt == 4'd0) stateNext = CAPTURE;
            CAPTURE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= stateNext;
    end

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            oACK0      <= 1'b0;
            oACK1      <= 1'b0;
            oWH_IN     <= '0;
            oRES       <= '0;
            oRES_VALID <= 1'b0;
            oRES_SRC   <= 1'b0;
            oBUSY      <= 1'b0;
            ptr        <= 1'b0;
            src        <= 1'b0;
            cnt        <= '0;
        end else begin
            oACK0      <= 1'b0;
            oACK1      <= 1'b0;
            oRES_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        oWH_IN <= winner ? iVEC1 : vec0;
                        oACK0  <= !winner;
                        oACK1  <= winner;
                        src    <= winner;
                        ptr    <= !winner;
                        cnt    <= CNT_INIT;
                        oBUSY  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                CAPTURE: begin
                    oRES       <= iWH_S;
                    oRES_SRC   <= src;
                    oRES_VALID <= 1'b1;
                    oBUSY      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/walsh_seq_ctrl.md
Name: walsh_seq_ctrl

Overview:
- Scheduler that shares the single 8-point Walsh–Hadamard datapath between two requesters.
  - Requester 0: switch bank.
  - Requester 1: test-pattern / host source.
- Round-robin arbitration; latches the winning 8-bit vector onto the datapath inputs, waits a fixed settle latency, then captures the eight 5-bit coefficients into a holding register for the seven-segment display path.
- Sits between the board I/O top level and the walsh datapath instance.

Parameters:
- LAT, 2, clock cycles the walsh datapath needs after an input change before its outputs are stable; legal range 1..15.
- CW, 5, width of one coefficient; fixed by the datapath.

Ports:
- iCLK_50  in  1  system clock, 50 MHz, all logic on rising edge
- iRST_N  in  1  asynchronous active-low reset
- iREQ0  in  1  requester 0 request, level, held until oACK0
- iVEC0  in  8  requester 0 input vector, stable while iREQ0=1
- iREQ1  in  1  requester 1 request, level, held until oACK1
- iVEC1  in  8  requester 1 input vector, stable while iREQ1=1
- oACK0  out  1  one-cycle grant/accept pulse to requester 0
- oACK1  out  1  one-cycle grant/accept pulse to requester 1
- oWH_IN  out  8  drives walsh inputs i0..i7 (bit k -> ik)
- iWH_S  in  40  walsh outputs, s0 at [4:0] ... s7 at [39:35]
- oRES  out  40  captured coefficients, same packing as iWH_S
- oRES_VALID  out  1  one-cycle pulse when oRES updated
- oRES_SRC  out  1  requester id of the current oRES
- oBUSY  out  1  high while a transform is in flight

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, round-robin pointer = 0, counter 0.
- States: IDLE, WAIT, CAPTURE.
- IDLE, no request: outputs hold; oACKx = 0.
- IDLE, request(s) present at rising edge:
  - Winner selection: if only one iREQ is high, that requester wins regardless of pointer; if both are high, the requester named by the pointer wins.
  - On the same edge: oWH_IN <= winner vector; oACKwinner <= 1 for exactly one cycle; src <= winner id; pointer <= ~winner; cnt <= LAT-1; state <= WAIT; oBUSY <= 1.
- WAIT:
  - cnt == 0 -> state <= CAPTURE.
  - Otherwise cnt <= cnt-1.
  - oWH_IN held constant.
- CAPTURE:
  - oRES <= iWH_S; oRES_SRC <= src; oRES_VALID <= 1 for one cycle.
  - state <= IDLE; oBUSY <= 0.
- Latency:
  - Grant edge t.
  - oRES_VALID high in the cycle after edge t+LAT+1.
  - Back-to-back throughput: one transform per LAT+2 cycles.
- Requests while busy: not sampled, no ACK; a request still held is arbitrated at the next IDLE cycle.
- Request dropped before ACK: discarded, no side effect.
- Pointer fairness: with both requesters continuously requesting, grants alternate 0,1,0,1...
- oRES/oRES_SRC hold their value between captures; oWH_IN holds the last launched vector while idle.
- Reset mid-operation: immediate return to reset values; no ACK or VALID is produced for the aborted transform.
- Pure control: no arithmetic on coefficients; iWH_S captured verbatim (signed interpretation belongs to the display decoders).

Optional Feature:
- Macro: WALSH_SEQ_AUTOCHG_EN.
- Defined:
  - Requester 0 is change-driven; iREQ0 is ignored.
  - Internal request 0 asserts when iVEC0 differs from the last vector launched for source 0, and once unconditionally after reset.
  - The comparison register updates at grant.
  - iVEC0 first passes a 2-flop synchronizer.
  - oACK0 still pulses.
- Not defined: iREQ0 is used directly; no synchronizer or compare register is instantiated.

Test Plan:
- Bench walsh model: iWH_S = {8{oWH_IN[4:0]}} after LAT=2 cycles.
- Reset values: assert iRST_N=0 mid-WAIT -> all outputs 0 immediately; after release, no oRES_VALID without a new request.
- Single request: iREQ0=1, iVEC0=8'h15 at edge t -> oACK0 pulse at t+1, oWH_IN=8'h15, oBUSY=1; oRES_VALID after edge t+3, oRES={8{5'h15}}, oRES_SRC=0.
- Simultaneous requests: iREQ0 and iREQ1 held high with vectors 8'h01 and 8'h1F -> grants 0,1,0,1; oRES alternates {8{5'h01}}/{8{5'h1F}}; VALID pulses exactly 4 cycles apart.
- Busy blocking: iREQ1 rises one cycle after the grant to 0 -> no oACK1 until state returns to IDLE; oACK1 then pulses with no idle gap.
- Dropped request: iREQ1 pulsed for 1 cycle while busy -> no oACK1, no extra VALID.
- WALSH_SEQ_AUTOCHG_EN build: iVEC0 0x00 -> 0x0A with iREQ0=0 -> exactly one launch after the synchronizer delay, oRES={8{5'h0A}}; iVEC0 left static -> no further VALID.
